flag_checkpoint_regfile: RTL and testbench
==========================================

# flag_checkpoint_regfile

Parametrised flag register file for the WISC pipeline: WIDTH condition-flag bits (default Z,V,N) with per-bit write enables and two independent read ports. Unlike the earlier flag register, reads are muxed (no tristate bitlines), writes are bypassed to the read ports in the same cycle, and a DEPTH-entry checkpoint stack supports saving and restoring flags around speculative branches. It sits beside the main register file, written from EX and read by the branch unit and debug logic.

## Interface
- WIDTH, 3, number of flag bits (bit 2 = Z, 1 = V, 0 = N at default width)
- DEPTH, 4, checkpoint stack entries, ≥1
- CW, $clog2(DEPTH+1), derived width of ckpt_count (localparam)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_data  in  WIDTH  new flag values
- wr_mask  in  WIDTH  per-bit write enable; bit i set writes wr_data[i]
- rd_en1  in  1  read port 1 enable
- rd_en2  in  1  read port 2 enable
- rd_data1  out  WIDTH  port 1 data; 0 when rd_en1 low
- rd_data2  out  WIDTH  port 2 data; 0 when rd_en2 low
- ckpt_push  in  1  save current flags onto stack
- ckpt_pop  in  1  restore flags from stack top, remove entry
- ckpt_drop  in  1  discard stack top without restore (commit)
- ckpt_count  out  CW  entries held, 0..DEPTH
- full  out  1  ckpt_count == DEPTH
- empty  out  1  ckpt_count == 0
- err  out  1  sticky protocol-error flag
- err_clr  in  1  clears err

## Operation
- State: flags[WIDTH], stack[DEPTH][WIDTH], count[CW], err.
- Write: for each bit i with wr_mask[i]=1, flags[i] <= wr_data[i]; unmasked bits hold.
- Read (combinational): when rd_enN=1, rd_dataN = (flags & ~wr_mask) | (wr_data & wr_mask), i.e. the write is forwarded. If a valid pop occurs in the same cycle, there is no forwarding; rd_dataN = flags. When rd_enN=0, rd_dataN = 0.
- Stack ops, exactly one of push/pop/drop asserted:
  - push, not full: stack[count] <= flags (pre-write value, before any same-cycle write); count+1. Same-cycle write still updates flags.
  - pop, not empty: flags <= stack[count-1]; count-1; same-cycle write is discarded.
  - drop, not empty: count-1; flags unaffected; same-cycle write applies.
- Errors: the following are ignored (no state change except the write, which proceeds normally) and set err:
  - push when full
  - pop or drop when empty
  - two or more of push/pop/drop in the same cycle
- err persists until err_clr=1 or reset. An error event and err_clr in the same cycle leave err = 1.
- full, empty and ckpt_count are decoded from the count register only; they are not affected by the current-cycle request.

## Timing
- Reset (rst=0, asynchronous, immediate): flags=0, all stack entries=0, count=0, err=0.
  - Outputs during reset: ckpt_count=0, empty=1, full=0, err=0. rd_data is 0, or the bypassed wr_data when enabled.
- Release of reset is synchronous to the next clk edge. Reset asserted mid-sequence discards all checkpoints.
- Read latency is 0 cycles, combinational, including bypass. Write-to-register latency is 1 edge.
- Pop restore becomes visible on the read ports in the cycle after the pop edge.
- Push and pop are back-to-back capable every cycle. Push-then-pop on consecutive cycles restores the pushed value.
- Count wraps never: saturation is enforced by the error rule.

## Test plan
- Reset and write: assert rst=0, then release; write wr_data=3'b101 with mask 3'b111 -> rd_data1 shows 3'b101 in the same cycle (bypass) and after the edge; then mask 3'b010 with data 3'b010 -> flags=3'b111.
- Read enables: rd_en1=1, rd_en2=0 with flags=3'b110 -> rd_data1=3'b110, rd_data2=0.
- Checkpoint and restore: flags=3'b001; push while writing 3'b100 (mask 3'b111) -> count=1, flags=3'b100; pop -> flags=3'b001 next cycle, count=0, empty=1.
- Pop overrides write: stack top=3'b010, pop with wr_mask=3'b111, wr_data=3'b111 -> flags=3'b010; rd_data that cycle shows the old flags, not 3'b111.
- Full and empty boundaries (DEPTH=4): push 4 values 3'b001..3'b100 -> full=1, count=4; a 5th push -> count stays 4, err=1; 4 pops restore 3'b100,3'b011,3'b010,3'b001 in order; next pop -> err stays 1, flags unchanged; err_clr -> err=0.
- Drop, simultaneous ops and reset mid-stack: push 3'b011, then drop -> count=0, flags unchanged. push+pop in the same cycle -> err=1, count unchanged. With count=2, assert rst=0 asynchronously mid-cycle -> count=0, flags=0 immediately.

Source files
------------

// File: rtl/flag_checkpoint_regfile.sv
// Condition-flag register file with masked writes, write-to-read bypass and a
// checkpoint stack for saving/restoring flags around speculative branches.
module flag_checkpoint_regfile #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic             rd_en1,
    input  logic             rd_en2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             ckpt_push,
    input  logic             ckpt_pop,
    input  logic             ckpt_drop,
    output logic [CW-1:0]    ckpt_count,
    output logic             full,
    output logic             empty,
    output logic             err,
    input  logic             err_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] flags_q, flags_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;

    logic             multi_op;
    logic             push_ok, pop_ok, drop_ok, err_event;
    logic [AW-1:0]    push_idx, top_idx;
    logic [WIDTH-1:0] merged, rd_src;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign ckpt_count = count_q;
    assign err        = err_q;

    assign push_idx = count_q[AW-1:0];
    assign top_idx  = push_idx - AW'(1);

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        multi_op  = (32'(ckpt_push) + 32'(ckpt_pop) + 32'(ckpt_drop)) > 32'd1;
        push_ok   = ckpt_push && !multi_op && !full;
        pop_ok    = ckpt_pop  && !multi_op && !empty;
        drop_ok   = ckpt_drop && !multi_op && !empty;
        err_event = multi_op
                 || (ckpt_push && full)
                 || ((ckpt_pop || ckpt_drop) && empty);

        merged = (flags_q & ~wr_mask) | (wr_data & wr_mask);
        // A restoring pop owns the next flag value, so nothing is forwarded.
        rd_src = pop_ok ? flags_q : merged;

        flags_d = pop_ok ? stack_q[top_idx] : merged;

        stack_d = stack_q;
        if (push_ok) begin
            stack_d[push_idx] = flags_q;
        end

        count_d = count_q;
        if (push_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok || drop_ok) begin
            count_d = count_q - CW'(1);
        end

        // A same-cycle error event wins over err_clr.
        err_d = err_event ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    assign rd_data1 = rd_en1 ? rd_src : '0;
    assign rd_data2 = rd_en2 ? rd_src : '0;

    // NOTE: sequential state uses non-blocking assignments so all flops sample their _d values from the same pre-edge state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            // NOTE: the stack entries are reset too, so a restore after reset can never return stale pre-reset flags.
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

endmodule

// File: tb/tb_flag_checkpoint_regfile.sv
// Self-checking bench for flag_checkpoint_regfile: a table of per-cycle vectors
// fed through a scoreboard queue, plus hand sequences for reset corners.
module tb_flag_checkpoint_regfile;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] wr_data = '0, wr_mask = '0;
    logic       rd_en1 = 1'b0, rd_en2 = 1'b0;
    logic       ckpt_push = 1'b0, ckpt_pop = 1'b0, ckpt_drop = 1'b0, err_clr = 1'b0;
    logic [2:0] rd_data1, rd_data2, ckpt_count;
    logic       full, empty, err;

    int n_vec  = 0;
    int n_miss = 0;

    flag_checkpoint_regfile #(.WIDTH(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en1(rd_en1), .rd_en2(rd_en2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .ckpt_push(ckpt_push), .ckpt_pop(ckpt_pop), .ckpt_drop(ckpt_drop),
        .ckpt_count(ckpt_count), .full(full), .empty(empty),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // ctl = {rd_en1, rd_en2, push, pop, drop, err_clr}; fee = {full, empty, err}
    typedef struct {
        logic [2:0] wd;
        logic [2:0] wm;
        logic [5:0] ctl;
        logic [2:0] rd1;
        logic [2:0] rd2;
        logic [2:0] cnt;
        logic [2:0] fee;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] rd1;
        logic [2:0] rd2;
        logic [2:0] cnt;
        logic [2:0] fee;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] wd, input logic [2:0] wm, input logic [5:0] ctl);
        wr_data   = wd;
        wr_mask   = wm;
        rd_en1    = ctl[5];
        rd_en2    = ctl[4];
        ckpt_push = ctl[3];
        ckpt_pop  = ctl[2];
        ckpt_drop = ctl[1];
        err_clr   = ctl[0];
    endtask

    task automatic compare_pop();
        exp_t e;
        string tag;
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        tag = $sformatf("v%0d", e.idx);
        check({tag, "_rd1"}, 32'(rd_data1), 32'(e.rd1));
        check({tag, "_rd2"}, 32'(rd_data2), 32'(e.rd2));
        check({tag, "_cnt"}, 32'(ckpt_count), 32'(e.cnt));
        check({tag, "_fee"}, 32'({full, empty, err}), 32'(e.fee));
    endtask

    initial begin
        // Main table: expected outputs are the combinational values seen before each row's edge.
        vecs.push_back('{3'b101, 3'b111, 6'b110000, 3'b101, 3'b101, 3'd0, 3'b010}); // write all, bypass
        vecs.push_back('{3'b000, 3'b000, 6'b100000, 3'b101, 3'b000, 3'd0, 3'b010});
        vecs.push_back('{3'b010, 3'b010, 6'b110000, 3'b111, 3'b111, 3'd0, 3'b010}); // masked write
        vecs.push_back('{3'b000, 3'b001, 6'b100000, 3'b110, 3'b000, 3'd0, 3'b010});
        vecs.push_back('{3'b000, 3'b000, 6'b100000, 3'b110, 3'b000, 3'd0, 3'b010}); // rd_en2 low
        vecs.push_back('{3'b001, 3'b111, 6'b110000, 3'b001, 3'b001, 3'd0, 3'b010});
        vecs.push_back('{3'b100, 3'b111, 6'b101000, 3'b100, 3'b000, 3'd0, 3'b010}); // push + write
        vecs.push_back('{3'b000, 3'b000, 6'b100000, 3'b100, 3'b000, 3'd1, 3'b000});
        vecs.push_back('{3'b000, 3'b000, 6'b100100, 3'b100, 3'b000, 3'd1, 3'b000}); // pop
        vecs.push_back('{3'b000, 3'b000, 6'b110000, 3'b001, 3'b001, 3'd0, 3'b010}); // restored
        vecs.push_back('{3'b010, 3'b111, 6'b100000, 3'b010, 3'b000, 3'd0, 3'b010});
        vecs.push_back('{3'b000, 3'b000, 6'b101000, 3'b010, 3'b000, 3'd0, 3'b010}); // push 010
        vecs.push_back('{3'b110, 3'b111, 6'b100000, 3'b110, 3'b000, 3'd1, 3'b000});
        vecs.push_back('{3'b111, 3'b111, 6'b110100, 3'b110, 3'b110, 3'd1, 3'b000}); // pop beats write
        vecs.push_back('{3'b000, 3'b000, 6'b100000, 3'b010, 3'b000, 3'd0, 3'b010});
        vecs.push_back('{3'b001, 3'b111, 6'b100000, 3'b001, 3'b000, 3'd0, 3'b010});
        vecs.push_back('{3'b010, 3'b111, 6'b101000, 3'b010, 3'b000, 3'd0, 3'b010}); // push 001
        vecs.push_back('{3'b011, 3'b111, 6'b101000, 3'b011, 3'b000, 3'd1, 3'b000}); // push 010
        vecs.push_back('{3'b100, 3'b111, 6'b101000, 3'b100, 3'b000, 3'd2, 3'b000}); // push 011
        vecs.push_back('{3'b101, 3'b111, 6'b101000, 3'b101, 3'b000, 3'd3, 3'b000}); // push 100
        vecs.push_back('{3'b000, 3'b000, 6'b100000, 3'b101, 3'b000, 3'd4, 3'b100}); // full
        vecs.push_back('{3'b110, 3'b111, 6'b101000, 3'b110, 3'b000, 3'd4, 3'b100}); // push when full
        vecs.push_back('{3'b000, 3'b000, 6'b100100, 3'b110, 3'b000, 3'd4, 3'b101}); // pop -> 100
        vecs.push_back('{3'b000, 3'b000, 6'b100100, 3'b100, 3'b000, 3'd3, 3'b001}); // pop -> 011
        vecs.push_back('{3'b000, 3'b000, 6'b100100, 3'b011, 3'b000, 3'd2, 3'b001}); // pop -> 010
        vecs.push_back('{3'b000, 3'b000, 6'b100100, 3'b010, 3'b000, 3'd1, 3'b001}); // pop -> 001
        vecs.push_back('{3'b000, 3'b000, 6'b100100, 3'b001, 3'b000, 3'd0, 3'b011}); // pop when empty
        vecs.push_back('{3'b000, 3'b000, 6'b100001, 3'b001, 3'b000, 3'd0, 3'b011}); // err_clr
        vecs.push_back('{3'b000, 3'b000, 6'b100000, 3'b001, 3'b000, 3'd0, 3'b010});
        vecs.push_back('{3'b011, 3'b111, 6'b100000, 3'b011, 3'b000, 3'd0, 3'b010});
        vecs.push_back('{3'b000, 3'b000, 6'b101000, 3'b011, 3'b000, 3'd0, 3'b010}); // push 011
        vecs.push_back('{3'b111, 3'b111, 6'b100000, 3'b111, 3'b000, 3'd1, 3'b000});
        vecs.push_back('{3'b000, 3'b001, 6'b100010, 3'b110, 3'b000, 3'd1, 3'b000}); // drop + write
        vecs.push_back('{3'b000, 3'b000, 6'b100000, 3'b110, 3'b000, 3'd0, 3'b010});
        vecs.push_back('{3'b000, 3'b000, 6'b101100, 3'b110, 3'b000, 3'd0, 3'b010}); // push+pop
        vecs.push_back('{3'b000, 3'b000, 6'b100000, 3'b110, 3'b000, 3'd0, 3'b011});
        vecs.push_back('{3'b000, 3'b000, 6'b100101, 3'b110, 3'b000, 3'd0, 3'b011}); // error + clr
        vecs.push_back('{3'b000, 3'b000, 6'b100001, 3'b110, 3'b000, 3'd0, 3'b011});
        vecs.push_back('{3'b000, 3'b000, 6'b100000, 3'b110, 3'b000, 3'd0, 3'b010});
        vecs.push_back('{3'b001, 3'b111, 6'b101000, 3'b001, 3'b000, 3'd0, 3'b010}); // push 110
        vecs.push_back('{3'b000, 3'b000, 6'b100100, 3'b001, 3'b000, 3'd1, 3'b000}); // pop back-to-back
        vecs.push_back('{3'b000, 3'b000, 6'b110000, 3'b110, 3'b110, 3'd0, 3'b010});

        // Outputs while held in reset, with a bypassed write visible.
        drive(3'b101, 3'b111, 6'b110000);
        #2;
        check("rst_count", 32'(ckpt_count), 32'd0);
        check("rst_fee", 32'({full, empty, err}), 32'b010);
        check("rst_bypass", 32'(rd_data1), 32'b101);
        drive(3'b000, 3'b000, 6'b110000);
        #1;
        check("rst_rd_zero", 32'(rd_data2), 32'b000);

        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].wd, vecs[i].wm, vecs[i].ctl);
            sb.push_back('{i, vecs[i].rd1, vecs[i].rd2, vecs[i].cnt, vecs[i].fee});
            #2;
            compare_pop();
        end

        // Asynchronous reset mid-cycle with two checkpoints held.
        @(negedge clk);
        drive(3'b011, 3'b111, 6'b101000);
        @(negedge clk);
        drive(3'b101, 3'b111, 6'b101000);
        @(negedge clk);
        drive(3'b000, 3'b000, 6'b100000);
        #2;
        check("pre_rst_count", 32'(ckpt_count), 32'd2);
        check("pre_rst_flags", 32'(rd_data1), 32'b101);
        rst = 1'b0;
        #1;
        check("async_rst_count", 32'(ckpt_count), 32'd0);
        check("async_rst_flags", 32'(rd_data1), 32'b000);
        check("async_rst_fee", 32'({full, empty, err}), 32'b010);
        @(negedge clk);
        rst = 1'b1;
        drive(3'b000, 3'b000, 6'b100100);
        #2;
        check("post_rst_pop_empty_cnt", 32'(ckpt_count), 32'd0);
        @(negedge clk);
        drive(3'b000, 3'b000, 6'b100000);
        #2;
        check("post_rst_err", 32'(err), 32'd1);
        check("post_rst_flags", 32'(rd_data1), 32'b000);

        if (sb.size() != 0) check("scoreboard_leftover", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
